// File: rtl/mini6502_top_if.sv
// mini6502_top_if: exported CPU bus (address, write data, read/write strobe).
interface mini6502_top_if;
  logic [15:0] address;
  logic [7:0]  data_out;
  logic        rw;

  modport master (
    output address,
    output data_out,
    output rw
  );

  modport slave (
    input address,
    input data_out,
    input rw
  );
endinterface

// File: rtl/mini6502_top.sv
// mini6502_top: reduced 6502-subset CPU with on-board ROM ($F000-$FFFF) and
// zero-page RAM ($0000-$00FF). One bus cycle per ph1 rising edge.

module mini6502_mem #(
  parameter int ROM_AW = 12,
  parameter int RAM_AW = 8
) (
  input  logic              clk,
  input  logic [15:0]       address,
  input  logic [7:0]        wdata,
  input  logic              rw,
  input  logic              rom_we,
  input  logic [ROM_AW-1:0] rom_wa,
  input  logic [7:0]        rom_wd,
  output logic [7:0]        rdata
);
  logic [7:0] ROM [0:(1<<ROM_AW)-1];
  logic [7:0] RAM [0:(1<<RAM_AW)-1];
  logic       rom_sel;
  logic       ram_sel;

  assign rom_sel = &address[15:ROM_AW];
  assign ram_sel = ~|address[15:RAM_AW];

  // combinational read; unmapped space floats high
  always_comb begin
    rdata = 8'hFF;
    if (rom_sel)      rdata = ROM[address[ROM_AW-1:0]];
    else if (ram_sel) rdata = RAM[address[RAM_AW-1:0]];
  end

  // zero-page write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (!rw && ram_sel) RAM[address[RAM_AW-1:0]] <= wdata;
  end

  // ROM image load port; tied off in the system, image is preloaded
  always_ff @(posedge clk) begin
    if (rom_we) ROM[rom_wa] <= rom_wd;
  end
endmodule

// state | meaning
// RST0  | read reset vector low byte at $FFFC
// RST1  | read reset vector high byte at $FFFD
// T0    | opcode fetch at PC, PC advances
// T1    | operand or dummy fetch at PC; most instructions complete here
// T2    | zero-page access at $00zz, or JMP high-byte fetch at PC
module mini6502_top #(
  parameter int ROM_AW = 12,
  parameter int RAM_AW = 8
) (
  input  logic           ph1,
  input  logic           reset,
  mini6502_top_if.master bus
);
  localparam logic [2:0] S_RST0 = 3'd0;
  localparam logic [2:0] S_RST1 = 3'd1;
  localparam logic [2:0] S_T0   = 3'd2;
  localparam logic [2:0] S_T1   = 3'd3;
  localparam logic [2:0] S_T2   = 3'd4;

  logic [2:0]  state;
  logic [15:0] pc;
  logic [7:0]  ir;
  logic [7:0]  opl;
  logic [7:0]  a;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        flag_n;
  logic        flag_z;
  logic        flag_c;
  logic [7:0]  data_in;
  logic [15:0] addr;
  logic        rw;
  logic        op_jmp;
  logic        op_sta;
  logic [8:0]  sum;
  logic [8:0]  diff;
  logic        br_taken;
  logic [15:0] br_target;

  function automatic logic [1:0] nz(input logic [7:0] v);
    return {v[7], v == 8'h00};
  endfunction

  assign op_jmp = (ir == 8'h4C);
  assign op_sta = (ir == 8'h85);

  // bus address follows the state: vector bytes, PC, or zero-page operand
  always_comb begin
    addr = pc;
    case (state)
      S_RST0:  addr = 16'hFFFC;
      S_RST1:  addr = 16'hFFFD;
      S_T2:    addr = op_jmp ? pc : {8'h00, opl};
      default: addr = pc;
    endcase
  end

  // only the STA memory cycle writes; reset forces a read at once
  assign rw           = ~((state == S_T2) && op_sta);
  assign bus.address  = addr;
  assign bus.data_out = a;
  assign bus.rw       = rw;

  mini6502_mem #(
    .ROM_AW (ROM_AW),
    .RAM_AW (RAM_AW)
  ) mem (
    .clk     (ph1),
    .address (addr),
    .wdata   (a),
    .rw      (rw),
    .rom_we  (1'b0),
    .rom_wa  ('0),
    .rom_wd  ('0),
    .rdata   (data_in)
  );

  // adder, comparator and branch target for the byte currently on the bus
  always_comb begin
    sum       = {1'b0, a} + {1'b0, data_in} + {8'h00, flag_c};
    diff      = {1'b0, a} - {1'b0, data_in};
    br_taken  = (ir == 8'hD0) ? ~flag_z : flag_z;
    br_target = pc + 16'd1 + (br_taken ? {{8{data_in[7]}}, data_in} : 16'h0000);
  end

  // sequencer and register file
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state  <= S_RST0;
      pc     <= 16'h0000;
      ir     <= 8'h00;
      opl    <= 8'h00;
      a      <= 8'h00;
      x      <= 8'h00;
      y      <= 8'h00;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      case (state)
        S_RST0: begin
          pc[7:0] <= data_in;
          state   <= S_RST1;
        end
        S_RST1: begin
          pc[15:8] <= data_in;
          state    <= S_T0;
        end
        S_T0: begin
          ir    <= data_in;
          pc    <= pc + 16'd1;
          state <= S_T1;
        end
        S_T1: begin
          state <= S_T0;
          case (ir)
            8'hA9: begin a <= data_in; {flag_n, flag_z} <= nz(data_in); pc <= pc + 16'd1; end
            8'hA2: begin x <= data_in; {flag_n, flag_z} <= nz(data_in); pc <= pc + 16'd1; end
            8'hA0: begin y <= data_in; {flag_n, flag_z} <= nz(data_in); pc <= pc + 16'd1; end
            8'h69: begin
              {flag_c, a}      <= sum;
              {flag_n, flag_z} <= nz(sum[7:0]);
              pc               <= pc + 16'd1;
            end
            8'h29: begin a <= a & data_in; {flag_n, flag_z} <= nz(a & data_in); pc <= pc + 16'd1; end
            8'h09: begin a <= a | data_in; {flag_n, flag_z} <= nz(a | data_in); pc <= pc + 16'd1; end
            8'h49: begin a <= a ^ data_in; {flag_n, flag_z} <= nz(a ^ data_in); pc <= pc + 16'd1; end
            8'hC9: begin
              flag_c           <= ~diff[8];
              {flag_n, flag_z} <= nz(diff[7:0]);
              pc               <= pc + 16'd1;
            end
            8'hA5, 8'h65, 8'h85, 8'h4C: begin
              opl   <= data_in;
              pc    <= pc + 16'd1;
              state <= S_T2;
            end
            8'hD0, 8'hF0: pc <= br_target;
            8'hE8: begin x <= x + 8'd1; {flag_n, flag_z} <= nz(x + 8'd1); end
            8'hCA: begin x <= x - 8'd1; {flag_n, flag_z} <= nz(x - 8'd1); end
            8'hC8: begin y <= y + 8'd1; {flag_n, flag_z} <= nz(y + 8'd1); end
            8'h88: begin y <= y - 8'd1; {flag_n, flag_z} <= nz(y - 8'd1); end
            8'hAA: begin x <= a; {flag_n, flag_z} <= nz(a); end
            8'h8A: begin a <= x; {flag_n, flag_z} <= nz(x); end
            8'h18: flag_c <= 1'b0;
            8'h38: flag_c <= 1'b1;
            default: ;
          endcase
        end
        S_T2: begin
          state <= S_T0;
          case (ir)
            8'hA5: begin a <= data_in; {flag_n, flag_z} <= nz(data_in); end
            8'h65: begin
              {flag_c, a}      <= sum;
              {flag_n, flag_z} <= nz(sum[7:0]);
            end
            8'h4C: pc <= {data_in, opl};
            default: ;
          endcase
        end
        default: state <= S_RST0;
      endcase
    end
  end
endmodule

// File: tb/tb_mini6502_top.sv
// tb_mini6502_top: directed program checks plus random programs compared
// cycle by cycle against an instruction-level reference model.
module tb_mini6502_top;
  logic ph1   = 1'b0;
  logic reset = 1'b0;

  mini6502_top_if bus ();

  mini6502_top dut (
    .ph1   (ph1),
    .reset (reset),
    .bus   (bus)
  );

  always #5 ph1 = ~ph1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  dout;
  } cyc_t;

  logic [7:0]  m_rom [0:4095];
  logic [7:0]  m_ram [0:255];
  logic [15:0] m_pc;
  logic [7:0]  m_a, m_x, m_y;
  logic        m_n, m_z, m_c;
  cyc_t        exp_q [$];
  logic        pend_wr = 1'b0;
  logic [7:0]  pend_ad, pend_d;

  logic [7:0] op_tab [0:25] = '{8'hA9, 8'hA2, 8'hA0, 8'h69, 8'h29, 8'h09, 8'h49, 8'hC9,
                                8'hA5, 8'h65, 8'h85, 8'h4C, 8'hD0, 8'hF0, 8'hE8, 8'hCA,
                                8'hC8, 8'h88, 8'hAA, 8'h8A, 8'h18, 8'h38, 8'hEA, 8'hD0,
                                8'hF0, 8'h85};

  function automatic logic [7:0] rd(input logic [15:0] ad);
    if (ad >= 16'hF000) return m_rom[ad[11:0]];
    if (ad < 16'h0100)  return m_ram[ad[7:0]];
    return 8'hFF;
  endfunction

  function automatic int op_len(input logic [7:0] op);
    case (op)
      8'hA9, 8'hA2, 8'hA0, 8'h69, 8'h29, 8'h09, 8'h49, 8'hC9,
      8'hA5, 8'h65, 8'h85, 8'hD0, 8'hF0: return 1;
      8'h4C: return 2;
      default: return 0;
    endcase
  endfunction

  task automatic rd_cyc(input logic [15:0] ad, output logic [7:0] v);
    v = rd(ad);
    exp_q.push_back({ad, 1'b1, 8'h00});
  endtask

  task automatic setnz(input logic [7:0] v);
    m_n = v[7];
    m_z = (v == 8'h00);
  endtask

  task automatic m_exec(input logic [7:0] op, input logic [7:0] m);
    int r;
    case (op)
      8'hA9, 8'hA5: begin m_a = m; setnz(m_a); end
      8'hA2: begin m_x = m; setnz(m_x); end
      8'hA0: begin m_y = m; setnz(m_y); end
      8'h69, 8'h65: begin
        r   = int'(m_a) + int'(m) + (m_c ? 1 : 0);
        m_c = (r > 255);
        m_a = 8'(r);
        setnz(m_a);
      end
      8'h29: begin m_a = m_a & m; setnz(m_a); end
      8'h09: begin m_a = m_a | m; setnz(m_a); end
      8'h49: begin m_a = m_a ^ m; setnz(m_a); end
      8'hC9: begin m_c = (m_a >= m); setnz(8'(int'(m_a) - int'(m))); end
      8'hE8: begin m_x = 8'(int'(m_x) + 1); setnz(m_x); end
      8'hCA: begin m_x = 8'(int'(m_x) - 1); setnz(m_x); end
      8'hC8: begin m_y = 8'(int'(m_y) + 1); setnz(m_y); end
      8'h88: begin m_y = 8'(int'(m_y) - 1); setnz(m_y); end
      8'hAA: begin m_x = m_a; setnz(m_x); end
      8'h8A: begin m_a = m_x; setnz(m_a); end
      8'h18: m_c = 1'b0;
      8'h38: m_c = 1'b1;
      default: ;
    endcase
  endtask

  // one whole instruction: expected bus cycles queued, architectural state updated
  task automatic model_instr();
    logic [7:0] op, m, lo, hi;
    int off;
    logic taken;
    rd_cyc(m_pc, op);
    m_pc = m_pc + 16'd1;
    case (op)
      8'hA9, 8'hA2, 8'hA0, 8'h69, 8'h29, 8'h09, 8'h49, 8'hC9: begin
        rd_cyc(m_pc, m);
        m_pc = m_pc + 16'd1;
        m_exec(op, m);
      end
      8'hA5, 8'h65: begin
        rd_cyc(m_pc, lo);
        m_pc = m_pc + 16'd1;
        rd_cyc({8'h00, lo}, m);
        m_exec(op, m);
      end
      8'h85: begin
        rd_cyc(m_pc, lo);
        m_pc = m_pc + 16'd1;
        exp_q.push_back({8'h00, lo, 1'b0, m_a});
      end
      8'h4C: begin
        rd_cyc(m_pc, lo);
        m_pc = m_pc + 16'd1;
        rd_cyc(m_pc, hi);
        m_pc = {hi, lo};
      end
      8'hD0, 8'hF0: begin
        rd_cyc(m_pc, m);
        taken = (op == 8'hD0) ? !m_z : m_z;
        off   = m[7] ? int'(m) - 256 : int'(m);
        m_pc  = 16'(int'(m_pc) + 1 + (taken ? off : 0));
      end
      default: begin
        rd_cyc(m_pc, m);
        m_exec(op, m);
      end
    endcase
  endtask

  task automatic model_reset();
    m_a = 8'h00; m_x = 8'h00; m_y = 8'h00;
    m_n = 1'b0;  m_z = 1'b0;  m_c = 1'b0;
    exp_q.delete();
    exp_q.push_back({16'hFFFC, 1'b1, 8'h00});
    exp_q.push_back({16'hFFFD, 1'b1, 8'h00});
    m_pc = {rd(16'hFFFD), rd(16'hFFFC)};
  endtask

  task automatic commit_pend();
    if (pend_wr) m_ram[pend_ad] = pend_d;
    pend_wr = 1'b0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic put(input int idx, input logic [7:0] v);
    logic [11:0] i12;
    i12 = idx[11:0];
    m_rom[i12] = v;
    dut.mem.ROM[i12] <= v;
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 4096; i++) put(i, 8'hEA);
    put(12'hFFC, 8'h00);
    put(12'hFFD, 8'hF0);
  endtask

  task automatic check_regs();
    chk("reg_a", dut.a, m_a);
    chk("reg_x", dut.x, m_x);
    chk("reg_y", dut.y, m_y);
    chk("flags_nzc", {dut.flag_n, dut.flag_z, dut.flag_c}, {m_n, m_z, m_c});
  endtask

  task automatic do_reset(input int n);
    reset   = 1'b0;
    pend_wr = 1'b0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge ph1);
      chk("rst_address", bus.address, 16'hFFFC);
      chk("rst_rw", bus.rw, 1'b1);
      chk("rst_regs", {dut.a, dut.x, dut.y, dut.flag_n, dut.flag_z, dut.flag_c}, 27'h0);
    end
    @(posedge ph1);
    #2 reset = 1'b1;
    model_reset();
  endtask

  task automatic run_cycles(input int n);
    cyc_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge ph1);
      commit_pend();
      if (exp_q.size() == 0) begin
        check_regs();
        model_instr();
      end
      e = exp_q.pop_front();
      chk("address", bus.address, e.addr);
      chk("rw", bus.rw, e.rw);
      if (!e.rw) begin
        chk("data_out", bus.data_out, e.dout);
        if (e.addr < 16'h0100) begin
          pend_wr = 1'b1;
          pend_ad = e.addr[7:0];
          pend_d  = e.dout;
        end
      end
    end
  endtask

  task automatic random_round(input int ncyc);
    int p;
    int r;
    logic [7:0] op;
    reset = 1'b0;
    fill_rom();
    p = 0;
    // seed all of zero page first so later reads are defined
    for (int i = 0; i < 256; i++) begin
      put(p, 8'hA9); put(p + 1, 8'($urandom)); put(p + 2, 8'h85); put(p + 3, 8'(i));
      p += 4;
    end
    while (p < 12'hFF0) begin
      op = ($urandom_range(0, 15) == 0) ? 8'($urandom) : op_tab[$urandom_range(0, 25)];
      put(p, op);
      p++;
      if (op == 8'h4C) begin
        r = $urandom_range(0, 15);
        put(p, 8'($urandom));
        put(p + 1, (r < 14) ? 8'($urandom_range(8'hF4, 8'hFF)) : 8'h00);
        p += 2;
      end else if (op_len(op) == 1) begin
        put(p, 8'($urandom));
        p++;
      end
    end
    do_reset(2);
    run_cycles(1282 + ncyc);
    @(negedge ph1);
    commit_pend();
    for (int i = 0; i < 256; i++) chk("ram_image", dut.mem.RAM[i], m_ram[i]);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // reset vector and LDA/STA write cycle
    fill_rom();
    put(12'h000, 8'hA9); put(12'h001, 8'hCF); put(12'h002, 8'h85); put(12'h003, 8'h42);
    do_reset(5);
    run_cycles(1); chk("vec_fffc", bus.address, 16'hFFFC);
    run_cycles(1); chk("vec_fffd", bus.address, 16'hFFFD);
    run_cycles(1); chk("vec_f000", bus.address, 16'hF000);
    run_cycles(4);
    chk("sta_address", bus.address, 16'h0042);
    chk("sta_rw", bus.rw, 1'b0);
    chk("sta_data", bus.data_out, 8'hCF);
    run_cycles(1);
    chk("sta_ram", dut.mem.RAM[8'h42], 8'hCF);

    // LDX #3; DEX; BNE -3
    reset = 1'b0;
    fill_rom();
    put(12'h000, 8'hA2); put(12'h001, 8'h03); put(12'h002, 8'hCA);
    put(12'h003, 8'hD0); put(12'h004, 8'hFD);
    do_reset(3);
    run_cycles(17);
    chk("loop_exit_pc", bus.address, 16'hF005);
    chk("loop_x", dut.x, 8'h00);
    chk("loop_z", dut.flag_z, 1'b1);

    // ADC carry/zero, then CMP borrow
    reset = 1'b0;
    fill_rom();
    put(12'h000, 8'hA9); put(12'h001, 8'hFF); put(12'h002, 8'h18);
    put(12'h003, 8'h69); put(12'h004, 8'h01); put(12'h005, 8'h38);
    put(12'h006, 8'hA9); put(12'h007, 8'h10); put(12'h008, 8'hC9); put(12'h009, 8'h20);
    do_reset(3);
    run_cycles(9);
    chk("adc_a", dut.a, 8'h00);
    chk("adc_czn", {dut.flag_c, dut.flag_z, dut.flag_n}, 3'b110);
    run_cycles(6);
    chk("cmp_a", dut.a, 8'h10);
    chk("cmp_czn", {dut.flag_c, dut.flag_z, dut.flag_n}, 3'b001);

    // JMP $F010, then JMP $F000
    reset = 1'b0;
    fill_rom();
    put(12'h000, 8'h4C); put(12'h001, 8'h10); put(12'h002, 8'hF0);
    put(12'h010, 8'h4C); put(12'h011, 8'h00); put(12'h012, 8'hF0);
    do_reset(3);
    run_cycles(6); chk("jmp_f010", bus.address, 16'hF010);
    run_cycles(1); chk("jmp_f011", bus.address, 16'hF011);
    run_cycles(1); chk("jmp_f012", bus.address, 16'hF012);
    run_cycles(1); chk("jmp_f000", bus.address, 16'hF000);

    // reset during the STA memory cycle loses the write
    reset = 1'b0;
    fill_rom();
    put(12'h000, 8'hA9); put(12'h001, 8'h11); put(12'h002, 8'h85); put(12'h003, 8'h42);
    put(12'h004, 8'hA9); put(12'h005, 8'hCF); put(12'h006, 8'h85); put(12'h007, 8'h42);
    do_reset(3);
    run_cycles(12);
    chk("abort_pre_rw", bus.rw, 1'b0);
    reset = 1'b0;
    #1;
    chk("abort_address", bus.address, 16'hFFFC);
    chk("abort_rw", bus.rw, 1'b1);
    do_reset(3);
    run_cycles(1); chk("restart_fffc", bus.address, 16'hFFFC);
    run_cycles(1); chk("restart_fffd", bus.address, 16'hFFFD);
    chk("abort_ram", dut.mem.RAM[8'h42], 8'h11);
    run_cycles(4);

    // random programs against the reference model
    for (int k = 0; k < 4; k++) random_round(1500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
